// File: rtl/score_display_ctrl.sv
// BCD score counter (tick + bonus, saturating) driving a multiplexed common-anode 7-segment display.
// Optional high-score register is compiled in when SCORE_HISCORE_EN is defined.
module score_display_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 5000,
  parameter int SCORE_DIV   = 5000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    bonus_valid,
  input  logic [3:0]              bonus_val,
  input  logic                    show_hi,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [4*NUM_DIGITS-1:0] hi_bcd,
  output logic                    overflow,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [6:0]              CAT
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int TW = $clog2(SCORE_DIV);
  localparam int RW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [W-1:0]          score_q, score_d;
  logic [W-1:0]          hi_q, hi_d;
  logic                  ovf_q, ovf_d;
  logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            cat_q, cat_d;

  logic                  tick;
  logic [3:0]            bonus_clamped;
  logic [3:0]            inc;
  logic [4:0]            dsum;
  logic                  carry;
  logic [W-1:0]          sum_bcd;

  always_comb begin
    tick          = en && (tick_cnt_q == TW'(SCORE_DIV - 1));
    bonus_clamped = (bonus_val > 4'd9) ? 4'd9 : bonus_val;
    inc           = {3'b000, tick} + ((bonus_valid && en) ? bonus_clamped : 4'd0);

    // Ripple BCD add: inc enters digit 0, only a 0/1 carry moves upward.
    carry   = 1'b0;
    dsum    = '0;
    sum_bcd = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dsum  = {1'b0, score_q[4*i +: 4]} + ((i == 0) ? {1'b0, inc} : {4'b0000, carry});
      carry = (dsum > 5'd9);
      sum_bcd[4*i +: 4] = carry ? 4'(dsum - 5'd10) : dsum[3:0];
    end

    tick_cnt_d = tick_cnt_q;
    if (en) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    end

    score_d = score_q;
    ovf_d   = ovf_q;
    if (clr) begin
      score_d    = '0;
      ovf_d      = 1'b0;
      tick_cnt_d = '0;
    end else if (!ovf_q) begin
      if (carry) begin
        score_d = ALL_NINES;
        ovf_d   = 1'b1;
      end else begin
        score_d = sum_bcd;
      end
    end

`ifdef SCORE_HISCORE_EN
    hi_d = (clr && (score_q > hi_q)) ? score_q : hi_q;
`else
    hi_d = '0;
`endif
  end

  logic [W-1:0]          src;
  logic [3:0]            digit;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  zeros_above;
  logic                  wrap;
  logic [6:0]            seg;

`ifndef SCORE_HISCORE_EN
  logic unused_show_hi;
  assign unused_show_hi = show_hi;
`endif

  always_comb begin
`ifdef SCORE_HISCORE_EN
    src = show_hi ? hi_q : score_q;
`else
    src = score_q;
`endif
    // lead_zero[i] is set when digit i and every digit above it are zero.
    zeros_above = 1'b1;
    lead_zero   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zeros_above  = zeros_above && (src[4*i +: 4] == 4'd0);
      lead_zero[i] = zeros_above;
    end

    digit = src[{idx_q, 2'b00} +: 4];
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase

    wrap      = (ref_cnt_q == RW'(REFRESH_DIV - 1));
    ref_cnt_d = wrap ? '0 : ref_cnt_q + 1'b1;
    idx_d     = idx_q;
    an_d      = an_q;
    cat_d     = cat_q;
    // Anode and segments load together from the same index, so they never disagree.
    if (wrap) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      cat_d = ((idx_q != '0) && lead_zero[idx_q]) ? 7'h7F : seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      score_q    <= '0;
      hi_q       <= '0;
      ovf_q      <= 1'b0;
      ref_cnt_q  <= '0;
      idx_q      <= '0;
      an_q       <= '1;
      cat_q      <= 7'h7F;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      score_q    <= score_d;
      hi_q       <= hi_d;
      ovf_q      <= ovf_d;
      ref_cnt_q  <= ref_cnt_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      cat_q      <= cat_d;
    end
  end

  assign score_bcd = score_q;
  assign hi_bcd    = hi_q;
  assign overflow  = ovf_q;
  assign AN        = an_q;
  assign CAT       = cat_q;

endmodule
